coherence_bus_ctrl: RTL and testbench

// Snoop-bus responder and arbiter for the two MSI data-cache controllers.
// - Accepts read_miss / write_miss / invalidate / memory-access requests from CPU0 and CPU1.
// - Grants the bus to one CPU at a time and probes the other CPU's cache.
// - Returns the data source select and forwarded data, and broadcasts invalidates.
// - Sits between both cache controllers and the shared unified-memory port.

---
 rtl/coherence_bus_ctrl.sv | 175 +++++++++++++++++
 tb/tb_coherence_bus_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coherence_bus_ctrl.sv
// Snoop-bus arbiter/responder for two MSI data caches.
// Grants one CPU at a time, probes the peer cache and forwards its data.
module coherence_bus_ctrl #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 16,
  parameter int SNOOP_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        read_miss,
  input  logic [1:0]        write_miss,
  input  logic [1:0]        invalidate,
  input  logic [1:0]        mem_req,
  input  logic [ADDR_W-1:0] BICO0,
  input  logic [ADDR_W-1:0] BICO1,
  input  logic [1:0]        cpu_search_found,
  input  logic [DATA_W-1:0] send_other_proc_data0,
  input  logic [DATA_W-1:0] send_other_proc_data1,
  output logic [1:0]        grant,
  output logic [1:0]        cpu_search,
  output logic [ADDR_W-1:0] BOCI0,
  output logic [ADDR_W-1:0] BOCI1,
  output logic [1:0]        invalidate_from_other_cpu,
  output logic [1:0]        cpu_datasel0,
  output logic [1:0]        cpu_datasel1,
  output logic [DATA_W-1:0] other_proc_data0,
  output logic [DATA_W-1:0] other_proc_data1
);

  localparam int CW = 2;
  localparam logic [CW-1:0] CNT_INIT = CW'(SNOOP_LAT - 1);

  typedef enum logic [2:0] {
    IDLE, SNOOP, RESP, INVAL, HOLD
  } state_t;

  typedef enum logic [1:0] {
    K_INV, K_WM, K_RM, K_MEM
  } kind_t;

  state_t            state_q, state_d;
  kind_t             kind_q, win_kind;
  logic              owner_q, rr_ptr;
  logic              win, accept, other;
  logic [1:0]        pend;
  logic [ADDR_W-1:0] addr_q, win_addr;
  logic              found_q;
  logic [DATA_W-1:0] data_q;
  logic [CW-1:0]     cnt_q;

  logic [ADDR_W-1:0] boci [2];
  logic [1:0]        dsel [2];
  logic [DATA_W-1:0] opd  [2];

  assign pend   = read_miss | write_miss | invalidate | mem_req;
  assign accept = |pend;
  assign other  = ~owner_q;

  always_comb begin
    win = rr_ptr;
    if (pend == 2'b01)
      win = 1'b0;
    else if (pend == 2'b10)
      win = 1'b1;
    win_addr = win ? BICO1 : BICO0;
    if (invalidate[win])
      win_kind = K_INV;
    else if (write_miss[win])
      win_kind = K_WM;
    else if (read_miss[win])
      win_kind = K_RM;
    else
      win_kind = K_MEM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      kind_q  <= K_INV;
      owner_q <= 1'b0;
      rr_ptr  <= 1'b0;
      addr_q  <= '0;
      found_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && accept) begin
        owner_q <= win;
        kind_q  <= win_kind;
        addr_q  <= win_addr;
        rr_ptr  <= ~win;
        cnt_q   <= CNT_INIT;
      end
      if (state_q == SNOOP) begin
        if (cnt_q == '0) begin
          found_q <= cpu_search_found[other];
          data_q  <= other ? send_other_proc_data1
                           : send_other_proc_data0;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (win_kind)
            K_INV:       state_d = INVAL;
            K_WM, K_RM:  state_d = SNOOP;
            default:     state_d = HOLD;
          endcase
        end
      end
      SNOOP:  if (cnt_q == '0) state_d = RESP;
      RESP:   state_d = IDLE;
      INVAL:  state_d = IDLE;
      HOLD:   if (!mem_req[owner_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant                     = '0;
    cpu_search                = '0;
    invalidate_from_other_cpu = '0;
    boci[0] = '0;
    boci[1] = '0;
    dsel[0] = '0;
    dsel[1] = '0;
    opd[0]  = '0;
    opd[1]  = '0;
    unique case (state_q)
      IDLE: begin
        // memory traffic is granted in the accepting cycle
        if (rst_n && accept && win_kind == K_MEM)
          grant[win] = 1'b1;
      end
      SNOOP: begin
        cpu_search[other] = 1'b1;
        boci[other]       = addr_q;
      end
      RESP: begin
        grant[owner_q] = 1'b1;
        if (found_q) begin
          dsel[owner_q] = 2'b01;
          opd[owner_q]  = data_q;
        end
        if (kind_q == K_WM) begin
          invalidate_from_other_cpu[other] = 1'b1;
          boci[other] = addr_q;
        end
      end
      INVAL: begin
        grant[owner_q] = 1'b1;
        invalidate_from_other_cpu[other] = 1'b1;
        boci[other] = addr_q;
      end
      HOLD: grant[owner_q] = mem_req[owner_q];
      default: ;
    endcase
  end

  assign BOCI0            = boci[0];
  assign BOCI1            = boci[1];
  assign cpu_datasel0     = dsel[0];
  assign cpu_datasel1     = dsel[1];
  assign other_proc_data0 = opd[0];
  assign other_proc_data1 = opd[1];

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Bench for coherence_bus_ctrl: vector table, corner sequences,
// and random traffic against a transaction-level reference model.
module tb_coherence_bus_ctrl;

  localparam int L = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  read_miss, write_miss, invalidate, mem_req;
  logic [12:0] BICO0, BICO1;
  logic [1:0]  found;
  logic [15:0] sd0, sd1;

  logic [1:0]  grant_a, search_a, inv_a, sel0_a, sel1_a;
  logic [12:0] boci0_a, boci1_a;
  logic [15:0] opd0_a, opd1_a;
  logic [1:0]  grant_b, search_b, inv_b, sel0_b, sel1_b;
  logic [12:0] boci0_b, boci1_b;
  logic [15:0] opd0_b, opd1_b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  coherence_bus_ctrl #(.ADDR_W(13), .DATA_W(16), .SNOOP_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .read_miss(read_miss), .write_miss(write_miss),
    .invalidate(invalidate), .mem_req(mem_req),
    .BICO0(BICO0), .BICO1(BICO1),
    .cpu_search_found(found),
    .send_other_proc_data0(sd0), .send_other_proc_data1(sd1),
    .grant(grant_a), .cpu_search(search_a),
    .BOCI0(boci0_a), .BOCI1(boci1_a),
    .invalidate_from_other_cpu(inv_a),
    .cpu_datasel0(sel0_a), .cpu_datasel1(sel1_a),
    .other_proc_data0(opd0_a), .other_proc_data1(opd1_a)
  );

  coherence_bus_ctrl #(.ADDR_W(13), .DATA_W(16), .SNOOP_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .read_miss(read_miss), .write_miss(write_miss),
    .invalidate(invalidate), .mem_req(mem_req),
    .BICO0(BICO0), .BICO1(BICO1),
    .cpu_search_found(found),
    .send_other_proc_data0(sd0), .send_other_proc_data1(sd1),
    .grant(grant_b), .cpu_search(search_b),
    .BOCI0(boci0_b), .BOCI1(boci1_b),
    .invalidate_from_other_cpu(inv_b),
    .cpu_datasel0(sel0_b), .cpu_datasel1(sel1_b),
    .other_proc_data0(opd0_b), .other_proc_data1(opd1_b)
  );

  function automatic logic [95:0] pk_a();
    return {28'b0, grant_a, search_a, boci0_a, boci1_a, inv_a,
            sel0_a, sel1_a, opd0_a, opd1_a};
  endfunction

  function automatic logic [95:0] pk_b();
    return {28'b0, grant_b, search_b, boci0_b, boci1_b, inv_b,
            sel0_b, sel1_b, opd0_b, opd1_b};
  endfunction

  task automatic chk(input string name, input logic [95:0] act,
                     input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clr_in();
    read_miss = '0; write_miss = '0; invalidate = '0; mem_req = '0;
    BICO0 = '0; BICO1 = '0; found = '0; sd0 = '0; sd1 = '0;
  endtask

  task automatic do_reset();
    cyc();
    rst_n = 1'b0;
    clr_in();
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  // req bits: [3]=inv [2]=wm [1]=rm [0]=mem
  typedef struct {
    logic        cpu;
    logic [3:0]  req;
    logic [12:0] addr;
    logic        fnd;
    logic [15:0] pdata;
    logic [1:0]  e_grant;
    logic [1:0]  e_sel;
    logic [15:0] e_data;
    logic [1:0]  e_inv;
    logic [12:0] e_boci;
  } vec_t;

  task automatic drive_req(input logic c, input logic [3:0] r,
                           input logic [12:0] a);
    invalidate[c] = r[3];
    write_miss[c] = r[2];
    read_miss[c]  = r[1];
    mem_req[c]    = r[0];
    if (c) BICO1 = a; else BICO0 = a;
  endtask

  // random-phase state
  logic [3:0]  rq [2];
  logic [12:0] ra [2];
  int          mh [2];
  logic        m_busy, m_own, m_rr, m_found, p, w;
  int          m_kind, m_t;
  logic [12:0] m_addr;
  logic [15:0] m_data;
  logic [1:0]  e_grant, e_srch, e_inv, pend;
  logic [12:0] e_boci [2];
  logic [1:0]  e_sel [2];
  logic [15:0] e_opd [2];
  logic        done;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vt [7];
    vec_t v;
    logic o;
    vt[0] = '{1'b0, 4'b0010, 13'h0A4,  1'b1, 16'hBEEF,
              2'b01, 2'b01, 16'hBEEF, 2'b00, 13'h000};
    vt[1] = '{1'b1, 4'b0100, 13'h1F0,  1'b0, 16'h1234,
              2'b10, 2'b00, 16'h0000, 2'b01, 13'h1F0};
    vt[2] = '{1'b0, 4'b1000, 13'h055,  1'b1, 16'h7777,
              2'b01, 2'b00, 16'h0000, 2'b10, 13'h055};
    vt[3] = '{1'b1, 4'b0010, 13'h1FFF, 1'b1, 16'hFFFF,
              2'b10, 2'b01, 16'hFFFF, 2'b00, 13'h000};
    vt[4] = '{1'b0, 4'b0100, 13'h800,  1'b1, 16'hA5A5,
              2'b01, 2'b01, 16'hA5A5, 2'b10, 13'h800};
    vt[5] = '{1'b1, 4'b1110, 13'h333,  1'b1, 16'h4242,
              2'b10, 2'b00, 16'h0000, 2'b01, 13'h333};
    vt[6] = '{1'b0, 4'b0110, 13'h321,  1'b1, 16'h0F0F,
              2'b01, 2'b01, 16'h0F0F, 2'b10, 13'h321};

    clr_in();
    cyc();
    #1;
    chk("reset_a", pk_a(), '0);
    chk("reset_b", pk_b(), '0);
    do_reset();
    #1;
    chk("post_reset_a", pk_a(), '0);

    // vector table on the single-cycle-snoop instance
    for (int i = 0; i < 7; i++) begin
      v = vt[i];
      o = ~v.cpu;
      cyc();
      clr_in();
      drive_req(v.cpu, v.req, v.addr);
      found[o] = v.fnd;
      found[v.cpu] = ~v.fnd;
      if (o) begin sd1 = v.pdata; sd0 = ~v.pdata; end
      else begin sd0 = v.pdata; sd1 = ~v.pdata; end
      #1;
      chk("vec_accept_grant", grant_a, 2'b00);
      cyc();
      #1;
      if (!v.req[3]) begin
        chk("vec_search", search_a, o ? 2'b10 : 2'b01);
        cyc();
        #1;
      end
      chk("vec_resp",
          {grant_a, v.cpu ? sel1_a : sel0_a,
           v.cpu ? opd1_a : opd0_a, inv_a,
           o ? boci1_a : boci0_a},
          {v.e_grant, v.e_sel, v.e_data, v.e_inv, v.e_boci});
      cyc();
      clr_in();
    end

    // both CPUs invalidate together right after reset
    do_reset();
    invalidate = 2'b11;
    BICO0 = 13'h011;
    BICO1 = 13'h022;
    #1;
    cyc();
    #1;
    chk("dual_inv_first", {grant_a, inv_a, boci1_a},
        {2'b01, 2'b10, 13'h011});
    cyc();
    invalidate = 2'b10;
    #1;
    chk("dual_inv_idle", grant_a, 2'b00);
    cyc();
    #1;
    chk("dual_inv_second", {grant_a, inv_a, boci0_a},
        {2'b10, 2'b01, 13'h022});
    cyc();
    invalidate = 2'b00;
    cyc();
    invalidate = 2'b11;
    cyc();
    #1;
    chk("rr_back_to_cpu0", grant_a, 2'b01);
    cyc();
    invalidate = 2'b00;
    cyc();

    // mem_req held five cycles while CPU1 read-miss waits
    do_reset();
    mem_req = 2'b01;
    read_miss = 2'b10;
    BICO1 = 13'h0C0;
    #1;
    chk("hold_grant_c0", grant_a, 2'b01);
    for (int k = 1; k < 5; k++) begin
      cyc();
      #1;
      chk("hold_grant", {grant_a, search_a}, {2'b01, 2'b00});
    end
    cyc();
    mem_req = 2'b00;
    #1;
    chk("hold_drop", grant_a, 2'b00);
    cyc();
    #1;
    chk("hold_idle", {grant_a, search_a}, 4'b0000);
    cyc();
    #1;
    chk("hold_then_snoop", {search_a, boci0_a}, {2'b01, 13'h0C0});
    cyc();
    #1;
    chk("hold_then_resp", {grant_a, sel1_a}, {2'b10, 2'b00});
    cyc();
    clr_in();

    // three-cycle snoop with found toggling
    do_reset();
    read_miss = 2'b01;
    BICO0 = 13'h0A4;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      found = (k == 2) ? 2'b00 : 2'b10;
      sd1 = 16'(k * 16'h1111);
      #1;
      chk("lat3_search", {grant_b, search_b, boci1_b},
          {2'b00, 2'b10, 13'h0A4});
    end
    cyc();
    #1;
    chk("lat3_resp", {grant_b, sel0_b, opd0_b},
        {2'b01, 2'b01, 16'h3333});
    cyc();
    clr_in();

    // reset during snoop aborts; request re-arbitrated
    do_reset();
    write_miss = 2'b10;
    BICO1 = 13'h055;
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_b", pk_b(), '0);
    chk("rst_mid_a", pk_a(), '0);
    cyc();
    rst_n = 1'b1;
    #1;
    chk("rst_release", pk_b(), '0);
    cyc();
    #1;
    chk("rst_resnoop", {search_b, boci0_b}, {2'b01, 13'h055});
    cyc();
    cyc();
    cyc();
    #1;
    chk("rst_resp", {grant_b, inv_b, boci0_b},
        {2'b10, 2'b01, 13'h055});
    cyc();
    clr_in();

    // random traffic against the transaction model
    do_reset();
    rq[0] = '0; rq[1] = '0;
    ra[0] = '0; ra[1] = '0;
    mh[0] = 0;  mh[1] = 0;
    m_busy = 0; m_rr = 0; m_own = 0; m_kind = 0; m_t = 0;
    m_addr = '0; m_found = 0; m_data = '0;
    for (int cy = 0; cy < 600; cy++) begin
      if (cy != 0) cyc();
      for (int i = 0; i < 2; i++) begin
        if (rq[i] == 0 && $urandom_range(0, 2) == 0) begin
          rq[i] = 4'($urandom_range(1, 15));
          ra[i] = 13'($urandom);
          mh[i] = $urandom_range(1, 4);
        end
      end
      clr_in();
      drive_req(1'b0, rq[0], ra[0]);
      drive_req(1'b1, rq[1], ra[1]);
      found = 2'($urandom);
      sd0 = 16'($urandom);
      sd1 = 16'($urandom);
      #1;
      e_grant = '0; e_srch = '0; e_inv = '0;
      e_boci[0] = '0; e_boci[1] = '0;
      e_sel[0] = '0; e_sel[1] = '0;
      e_opd[0] = '0; e_opd[1] = '0;
      done = 0;
      if (!m_busy) begin
        pend = {|rq[1], |rq[0]};
        if (pend != 2'b00) begin
          w = (pend == 2'b11) ? m_rr : pend[1];
          m_kind = rq[w][3] ? 0 : rq[w][2] ? 1 : rq[w][1] ? 2 : 3;
          if (m_kind == 3) e_grant[w] = 1'b1;
          m_busy = 1; m_own = w; m_addr = ra[w]; m_t = 0; m_rr = ~w;
        end
      end else begin
        m_t++;
        p = ~m_own;
        if (m_kind == 0) begin
          e_grant[m_own] = 1'b1;
          e_inv[p] = 1'b1;
          e_boci[p] = m_addr;
          done = 1;
        end else if (m_kind == 3) begin
          if (rq[m_own][0]) e_grant[m_own] = 1'b1;
          else m_busy = 0;
        end else if (m_t <= L) begin
          e_srch[p] = 1'b1;
          e_boci[p] = m_addr;
          if (m_t == L) begin
            m_found = found[p];
            m_data = p ? sd1 : sd0;
          end
        end else begin
          e_grant[m_own] = 1'b1;
          if (m_found) begin
            e_sel[m_own] = 2'b01;
            e_opd[m_own] = m_data;
          end
          if (m_kind == 1) begin
            e_inv[p] = 1'b1;
            e_boci[p] = m_addr;
          end
          done = 1;
        end
      end
      chk("random_cycle", pk_a(),
          {28'b0, e_grant, e_srch, e_boci[0], e_boci[1], e_inv,
           e_sel[0], e_sel[1], e_opd[0], e_opd[1]});
      if (m_busy && m_kind == 3 && rq[m_own][0]) begin
        mh[m_own]--;
        if (mh[m_own] <= 0) rq[m_own] = '0;
      end
      if (done) begin
        rq[m_own] = '0;
        m_busy = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
